// File: rtl/regfile_pkg.sv
// Shared defaults and constants for the regfile_sb register file and its busy scoreboard.
package regfile_pkg;
    localparam int WIDTH_DEF    = 32;
    localparam int DEPTH_DEF    = 32;
    localparam int NUM_READ_DEF = 2;
    localparam int ZERO_ADDR    = 0;
endpackage

// File: rtl/regfile_sb_if.sv
// Bus bundle between issue/datapath logic (master) and the register file (slave).
interface regfile_sb_if
    import regfile_pkg::*;
#(
    parameter int WIDTH    = WIDTH_DEF,
    parameter int NUM_READ = NUM_READ_DEF,
    parameter int ADDR_W   = $clog2(DEPTH_DEF)
);
    logic [NUM_READ*ADDR_W-1:0] ReadRegister;
    logic [NUM_READ*WIDTH-1:0]  ReadData;
    logic [NUM_READ-1:0]        ReadBusy;
    logic [ADDR_W-1:0]          WriteRegister;
    logic [WIDTH-1:0]           WriteData;
    logic                       RegWrite;
    logic                       Reserve;
    logic [ADDR_W-1:0]          ReserveRegister;
    logic                       ReserveReady;
    logic [ADDR_W:0]            BusyCount;

    modport master (
        output ReadRegister, WriteRegister, WriteData, RegWrite, Reserve, ReserveRegister,
        input  ReadData, ReadBusy, ReserveReady, BusyCount
    );

    modport slave (
        input  ReadRegister, WriteRegister, WriteData, RegWrite, Reserve, ReserveRegister,
        output ReadData, ReadBusy, ReserveReady, BusyCount
    );
endinterface

// File: rtl/regfile_busy_sb.sv
// Per-register busy scoreboard: busy bit vector, reservation acceptance and busy count.
module regfile_busy_sb
    import regfile_pkg::*;
#(
    parameter int DEPTH    = DEPTH_DEF,
    parameter int ZERO_REG = 1,
    parameter int ADDR_W   = $clog2(DEPTH)
) (
    input  logic              Clk,
    input  logic              ResetN,
    input  logic              RegWrite,
    input  logic [ADDR_W-1:0] WriteRegister,
    input  logic              Reserve,
    input  logic [ADDR_W-1:0] ReserveRegister,
    output logic              ReserveReady,
    output logic [DEPTH-1:0]  busy,
    output logic [ADDR_W:0]   BusyCount
);
    logic             wrZero, resZero, writeEn, sameReg, reserveAcc, countInc, countDec;
    logic [DEPTH-1:0] busyNext;

    assign wrZero  = (ZERO_REG != 0) && (WriteRegister == ADDR_W'(ZERO_ADDR));
    assign resZero = (ZERO_REG != 0) && (ReserveRegister == ADDR_W'(ZERO_ADDR));
    assign writeEn = RegWrite && !wrZero;
    assign sameReg = (WriteRegister == ReserveRegister);

    // A busy register can be re-reserved in the cycle its producer writes back.
    assign ReserveReady = resZero || !busy[ReserveRegister] || (RegWrite && sameReg);
    assign reserveAcc   = Reserve && ReserveReady && !resZero;

    assign countInc = reserveAcc && !busy[ReserveRegister];
    assign countDec = writeEn && busy[WriteRegister] && !(reserveAcc && sameReg);

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        busyNext = busy;
        if (writeEn)    busyNext[WriteRegister]   = 1'b0;
        if (reserveAcc) busyNext[ReserveRegister] = 1'b1;
    end

    // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge Clk or negedge ResetN) begin
        if (!ResetN) begin
            busy      <= '0;
            BusyCount <= '0;
        end else begin
            busy <= busyNext;
            case ({countInc, countDec})
                2'b10:   BusyCount <= BusyCount + (ADDR_W+1)'(1);
                2'b01:   BusyCount <= BusyCount - (ADDR_W+1)'(1);
                default: BusyCount <= BusyCount;
            endcase
        end
    end
endmodule

// File: rtl/regfile_sb.sv
// Register file with busy scoreboard: async read ports, one sync write port, optional zero register.
// Define REGFILE_BYPASS_EN to forward same-cycle write data and busy clear to matching read ports.
module regfile_sb
    import regfile_pkg::*;
#(
    parameter int WIDTH    = WIDTH_DEF,
    parameter int DEPTH    = DEPTH_DEF,
    parameter int NUM_READ = NUM_READ_DEF,
    parameter int ZERO_REG = 1,
    parameter int ADDR_W   = $clog2(DEPTH)
) (
    input  logic        Clk,
    input  logic        ResetN,
    regfile_sb_if.slave bus
);
    logic [WIDTH-1:0]  mem [DEPTH];
    logic [DEPTH-1:0]  busy;
    logic [ADDR_W-1:0] rdAddr [NUM_READ];
    logic              writeEn;

    assign writeEn = bus.RegWrite &&
                     !((ZERO_REG != 0) && (bus.WriteRegister == ADDR_W'(ZERO_ADDR)));

    // NOTE: the storage array is reset because all registers must read 0 while reset is held.
    always_ff @(posedge Clk or negedge ResetN) begin
        if (!ResetN) begin
            for (int r = 0; r < DEPTH; r++) mem[r] <= '0;
        end else if (writeEn) begin
            mem[bus.WriteRegister] <= bus.WriteData;
        end
    end

    regfile_busy_sb #(
        .DEPTH   (DEPTH),
        .ZERO_REG(ZERO_REG),
        .ADDR_W  (ADDR_W)
    ) u_busy (
        .Clk            (Clk),
        .ResetN         (ResetN),
        .RegWrite       (bus.RegWrite),
        .WriteRegister  (bus.WriteRegister),
        .Reserve        (bus.Reserve),
        .ReserveRegister(bus.ReserveRegister),
        .ReserveReady   (bus.ReserveReady),
        .busy           (busy),
        .BusyCount      (bus.BusyCount)
    );

    always_comb begin
        for (int i = 0; i < NUM_READ; i++) rdAddr[i] = bus.ReadRegister[i*ADDR_W +: ADDR_W];
    end

    always_comb begin
        bus.ReadData = '0;
        bus.ReadBusy = '0;
        for (int i = 0; i < NUM_READ; i++) begin
            if (!((ZERO_REG != 0) && (rdAddr[i] == ADDR_W'(ZERO_ADDR)))) begin
                bus.ReadData[i*WIDTH +: WIDTH] = mem[rdAddr[i]];
                bus.ReadBusy[i]                = busy[rdAddr[i]];
            end
`ifdef REGFILE_BYPASS_EN
            if (writeEn && (bus.WriteRegister == rdAddr[i])) begin
                bus.ReadData[i*WIDTH +: WIDTH] = bus.WriteData;
                bus.ReadBusy[i]                = 1'b0;
            end
`endif
        end
    end
endmodule

// File: tb/tb_regfile_sb.sv
// Self-checking bench for regfile_sb (default parameters); expected values flow through a scoreboard queue.
module tb_regfile_sb;
    localparam int WIDTH = 32, DEPTH = 32, NUM_READ = 2, ADDR_W = 5;

    logic Clk;
    logic ResetN;
    int   checks   = 0;
    int   failures = 0;

    logic [31:0] expQ [$];
    logic [31:0] expV;

    regfile_sb_if #(.WIDTH(WIDTH), .NUM_READ(NUM_READ), .ADDR_W(ADDR_W)) bus ();

    regfile_sb #(
        .WIDTH(WIDTH), .DEPTH(DEPTH), .NUM_READ(NUM_READ), .ZERO_REG(1), .ADDR_W(ADDR_W)
    ) dut (
        .Clk   (Clk),
        .ResetN(ResetN),
        .bus   (bus)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic idle();
        bus.RegWrite        = 1'b0;
        bus.WriteRegister   = '0;
        bus.WriteData       = '0;
        bus.Reserve         = 1'b0;
        bus.ReserveRegister = '0;
    endtask

    task automatic set_read(input int a0, input int a1);
        bus.ReadRegister = {ADDR_W'(a1), ADDR_W'(a0)};
    endtask

    // Pops one expected value and compares it with the observed value.
    task automatic cmp(input string name, input logic [31:0] got);
        expV = expQ.pop_front();
        checks++;
        if (got !== expV) begin
            failures++;
            $display("FAIL %s got=%h expected=%h", name, got, expV);
        end
    endtask

    task automatic test_reset();
        expQ.push_back(32'd0); expQ.push_back(32'd1);
        expQ.push_back(32'd0); expQ.push_back(32'd0); expQ.push_back(32'd0);
        cmp("rst_busycount", 32'(bus.BusyCount));
        cmp("rst_reserveready", 32'(bus.ReserveReady));
        cmp("rst_readbusy", 32'(bus.ReadBusy));
        cmp("rst_rd0", bus.ReadData[31:0]);
        cmp("rst_rd1", bus.ReadData[63:32]);
    endtask

    task automatic test_write_read();
        bus.RegWrite = 1'b1; bus.WriteRegister = 5'd5; bus.WriteData = 32'hDEADBEEF;
        expQ.push_back(32'hDEADBEEF); expQ.push_back(32'd0);
        tick();
        idle();
        set_read(5, 0);
        #1;
        cmp("wr_rd_r5", bus.ReadData[31:0]);
        cmp("wr_rd_r0", bus.ReadData[63:32]);
    endtask

    task automatic test_zero_reg();
        bus.RegWrite = 1'b1; bus.WriteRegister = 5'd0; bus.WriteData = 32'h12345678;
        expQ.push_back(32'd0);
        tick();
        idle();
        set_read(0, 0);
        #1;
        cmp("zero_read", bus.ReadData[31:0]);
        bus.Reserve = 1'b1; bus.ReserveRegister = 5'd0;
        expQ.push_back(32'd1); expQ.push_back(32'd0); expQ.push_back(32'd0);
        #1;
        cmp("zero_reserveready", 32'(bus.ReserveReady));
        tick();
        idle();
        #1;
        cmp("zero_busycount", 32'(bus.BusyCount));
        cmp("zero_readbusy", 32'(bus.ReadBusy[0]));
    endtask

    task automatic test_reserve();
        bus.Reserve = 1'b1; bus.ReserveRegister = 5'd7;
        expQ.push_back(32'd1); expQ.push_back(32'd1);
        tick();
        idle();
        set_read(7, 7);
        #1;
        cmp("res_r7_busy", 32'(bus.ReadBusy[1]));
        cmp("res_count1", 32'(bus.BusyCount));
        bus.Reserve = 1'b1; bus.ReserveRegister = 5'd7;
        expQ.push_back(32'd0); expQ.push_back(32'd1);
        #1;
        cmp("res_waw_ready", 32'(bus.ReserveReady));
        tick();
        idle();
        #1;
        cmp("res_waw_count", 32'(bus.BusyCount));
        bus.RegWrite = 1'b1; bus.WriteRegister = 5'd7; bus.WriteData = 32'h77;
        expQ.push_back(32'd0); expQ.push_back(32'd0);
        tick();
        idle();
        #1;
        cmp("res_clr_busy", 32'(bus.ReadBusy[0]));
        cmp("res_clr_count", 32'(bus.BusyCount));
    endtask

    task automatic test_write_reserve_same();
        bus.Reserve = 1'b1; bus.ReserveRegister = 5'd9;
        tick();
        bus.Reserve = 1'b1; bus.ReserveRegister = 5'd9;
        bus.RegWrite = 1'b1; bus.WriteRegister = 5'd9; bus.WriteData = 32'h0000_0099;
        expQ.push_back(32'd1);
        #1;
        cmp("same_reserveready", 32'(bus.ReserveReady));
        expQ.push_back(32'h0000_0099); expQ.push_back(32'd1); expQ.push_back(32'd1);
        tick();
        idle();
        set_read(9, 0);
        #1;
        cmp("same_data", bus.ReadData[31:0]);
        cmp("same_busy", 32'(bus.ReadBusy[0]));
        cmp("same_count", 32'(bus.BusyCount));
        bus.RegWrite = 1'b1; bus.WriteRegister = 5'd9; bus.WriteData = 32'h0000_0099;
        expQ.push_back(32'd0);
        tick();
        idle();
        #1;
        cmp("same_release_count", 32'(bus.BusyCount));
    endtask

    task automatic test_bypass();
        // Write old value and reserve r3 together: r3 becomes busy holding 0x33.
        bus.RegWrite = 1'b1; bus.WriteRegister = 5'd3; bus.WriteData = 32'h33;
        bus.Reserve = 1'b1; bus.ReserveRegister = 5'd3;
        expQ.push_back(32'd1);
        tick();
        idle();
        #1;
        cmp("byp_setup_count", 32'(bus.BusyCount));
        set_read(3, 0);
        bus.RegWrite = 1'b1; bus.WriteRegister = 5'd3; bus.WriteData = 32'hA5A5A5A5;
`ifdef REGFILE_BYPASS_EN
        expQ.push_back(32'hA5A5A5A5); expQ.push_back(32'd0);
`else
        expQ.push_back(32'h33); expQ.push_back(32'd1);
`endif
        #1;
        cmp("byp_same_cycle_data", bus.ReadData[31:0]);
        cmp("byp_same_cycle_busy", 32'(bus.ReadBusy[0]));
        expQ.push_back(32'hA5A5A5A5); expQ.push_back(32'd0); expQ.push_back(32'd0);
        tick();
        idle();
        #1;
        cmp("byp_next_data", bus.ReadData[31:0]);
        cmp("byp_next_busy", 32'(bus.ReadBusy[0]));
        cmp("byp_next_count", 32'(bus.BusyCount));
    endtask

    task automatic test_back_to_back();
        for (int r = 1; r < DEPTH; r++) begin
            bus.Reserve = 1'b1; bus.ReserveRegister = ADDR_W'(r);
            tick();
        end
        idle();
        set_read(5, 31);
        expQ.push_back(32'd31); expQ.push_back(32'd1); expQ.push_back(32'd0);
        expQ.push_back(32'hDEADBEEF);
        #1;
        cmp("fill_count", 32'(bus.BusyCount));
        cmp("fill_busy_r31", 32'(bus.ReadBusy[1]));
        cmp("fill_ready_r0", 32'(!bus.ReserveReady));
        cmp("fill_rd_r5", bus.ReadData[31:0]);
        set_read(5, 9);
        #2;
        ResetN = 1'b0;
        expQ.push_back(32'd0); expQ.push_back(32'd0);
        expQ.push_back(32'd0); expQ.push_back(32'd0);
        #1;
        cmp("async_rst_count", 32'(bus.BusyCount));
        cmp("async_rst_busy", 32'(bus.ReadBusy));
        cmp("async_rst_rd0", bus.ReadData[31:0]);
        cmp("async_rst_rd1", bus.ReadData[63:32]);
        #2;
        ResetN = 1'b1;
        bus.RegWrite = 1'b1; bus.WriteRegister = 5'd2; bus.WriteData = 32'h22;
        expQ.push_back(32'h22); expQ.push_back(32'd0);
        tick();
        idle();
        set_read(2, 9);
        #1;
        cmp("post_rst_write", bus.ReadData[31:0]);
        cmp("post_rst_r9_cleared", bus.ReadData[63:32]);
    endtask

    initial begin
        ResetN = 1'b0;
        idle();
        set_read(5, 0);
        #2;
        test_reset();
        @(negedge Clk);
        ResetN = 1'b1;
        @(posedge Clk);
        #1;
        test_write_read();
        test_zero_reg();
        test_reserve();
        test_write_reserve_same();
        test_bypass();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
